// File: rtl/kore_pkg.sv
// Shared types and sizes for the kore register-bank responder.
package kore_pkg;

    localparam int unsigned KORE_XLEN   = 32;
    localparam int unsigned KORE_NREG   = 32;
    localparam int unsigned KORE_RSEL_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } kore_state_e;

    typedef struct packed {
        logic                   en;
        logic [KORE_RSEL_W-1:0] addr;
        logic [KORE_XLEN-1:0]   data;
    } kore_wr_t;

endpackage

// File: rtl/kore_rf_mem.sv
// 32x32 register array: one write port, two registered read ports with
// optional same-cycle write bypass; x0 always reads as zero.
module kore_rf_mem
    import kore_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  kore_wr_t               wr,
    input  logic                   a_en,
    input  logic [KORE_RSEL_W-1:0] a_addr,
    input  logic                   a_byp,
    output logic [KORE_XLEN-1:0]   a_data,
    input  logic [KORE_RSEL_W-1:0] b_addr,
    input  logic                   b_byp,
    output logic [KORE_XLEN-1:0]   b_data
);

    logic [KORE_XLEN-1:0] mem [KORE_NREG];

    logic                 wr_ok_c;
    logic                 a_hit_c;
    logic                 b_hit_c;
    logic [KORE_XLEN-1:0] a_next_c;
    logic [KORE_XLEN-1:0] b_next_c;

    // Bypass only forwards writes that actually land (nonzero address).
    always_comb begin
        wr_ok_c  = wr.en && (wr.addr != '0);
        a_hit_c  = a_byp && wr_ok_c && (wr.addr == a_addr);
        b_hit_c  = b_byp && wr_ok_c && (wr.addr == b_addr);
        a_next_c = (a_addr == '0) ? '0 : mem[a_addr];
        b_next_c = (b_addr == '0) ? '0 : mem[b_addr];
        if (a_hit_c) a_next_c = wr.data;
        if (b_hit_c) b_next_c = wr.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(KORE_NREG); i++) begin
                mem[i] <= '0;
            end
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (wr_ok_c) mem[wr.addr] <= wr.data;
            if (a_en) a_data <= a_next_c;
            b_data <= b_next_c;
        end
    end

endmodule

// File: rtl/kore_regbank.sv
// Register-bank responder for the kore function FSM: operand reads, result
// write-back, host load/inspect port and start/done handshake with timeout.
module kore_regbank
    import kore_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KORE_RSEL_W-1:0] reg_sel,
    input  logic                   reg_rd,
    input  logic                   wt_en,
    input  logic [KORE_XLEN-1:0]   wr_data,
    input  logic                   eop,
    output logic [KORE_XLEN-1:0]   data_bus,
    output logic                   opflag,
    input  logic                   host_start,
    output logic                   host_busy,
    output logic                   host_done,
    output logic                   host_err,
    input  logic                   host_we,
    input  logic [KORE_RSEL_W-1:0] host_addr,
    input  logic [KORE_XLEN-1:0]   host_wdata,
    input  logic [KORE_RSEL_W-1:0] host_raddr,
    output logic [KORE_XLEN-1:0]   host_rdata,
    output logic [CNT_W-1:0]       op_count
);

    localparam int unsigned TMO_W    = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    kore_state_e      state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             eop_q;
    logic             eop_rise_c;
    logic             fsm_wr_c;
    logic             host_wr_c;
    kore_wr_t         wr_c;

    // Write arbitration: the FSM owns the port in WAIT, the host in IDLE.
    always_comb begin
        eop_rise_c = eop && !eop_q;
        fsm_wr_c   = (state_q == WAIT) && wt_en;
        host_wr_c  = (state_q == IDLE) && host_we;
        wr_c.en    = fsm_wr_c || host_wr_c;
        wr_c.addr  = fsm_wr_c ? reg_sel : host_addr;
        wr_c.data  = fsm_wr_c ? wr_data : host_wdata;
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE:  if (host_start) state_d = ISSUE;
            ISSUE: begin
                state_d = WAIT;
                tmo_d   = '0;
            end
            WAIT: begin
                if (eop_rise_c) begin
                    state_d = DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ABORT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            eop_q     <= 1'b0;
            opflag    <= 1'b0;
            host_busy <= 1'b0;
            host_done <= 1'b0;
            host_err  <= 1'b0;
            op_count  <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            eop_q     <= eop;
            opflag    <= (state_d == ISSUE);
            host_busy <= (state_d != IDLE);
            host_done <= (state_d == DONE);
            host_err  <= (state_d == ABORT);
            if (state_d == DONE) op_count <= op_count + CNT_W'(1);
        end
    end

    kore_rf_mem u_rf (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr_c),
        .a_en   (reg_rd),
        .a_addr (reg_sel),
        .a_byp  (fsm_wr_c),
        .a_data (data_bus),
        .b_addr (host_raddr),
        .b_byp  (host_wr_c),
        .b_data (host_rdata)
    );

endmodule

// File: doc/kore_regbank.md
# kore_regbank

Register-bank responder at the far end of the kore function-FSM register interface. It holds 32 x 32-bit general registers. It serves the FSM's operand reads (`reg_sel`/`reg_rd` → `data_bus`) and accepts its result write-back (`wt_en`/`wr_data`). It also drives the FSM's `opflag` start pulse under a host start/done handshake with timeout, and gives the host a load/inspect port for register contents.

## Interface
Parameters:
- `TIMEOUT`, 64: max cycles in WAIT before aborting; legal range 2..65535.
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reg_sel` in 5: FSM register select.
- `reg_rd` in 1: FSM read strobe.
- `wt_en` in 1: FSM write enable.
- `wr_data` in 32: FSM write data (FSM `data_out`).
- `eop` in 1: FSM end-of-operation; level, may stay high for several cycles.
- `data_bus` out 32: registered read data to the FSM.
- `opflag` out 1: one-cycle start pulse to the FSM.
- `host_start` in 1: request one FSM operation.
- `host_busy` out 1: operation in progress.
- `host_done` out 1: one-cycle pulse, operation completed.
- `host_err` out 1: one-cycle pulse, timeout abort.
- `host_we` in 1, `host_addr` in 5, `host_wdata` in 32: host register write.
- `host_raddr` in 5: host read address.
- `host_rdata` out 32: registered host read data.
- `op_count` out `CNT_W`: number of completed operations.

## Operation
- x0 is hardwired to zero: reads return 0, and writes to address 0 from either port are discarded.
- FSM read: when `reg_rd`=1, `data_bus` <= `regs[reg_sel]`. When `reg_rd`=0, `data_bus` holds its value.
- Read/write bypass: if an accepted FSM write hits the same nonzero address as `reg_sel` in the same cycle, `data_bus` <= `wr_data`.
- FSM write is accepted only in WAIT, as `regs[reg_sel]` <= `wr_data` when `wt_en`=1. In any other state it is ignored.
- Host write is accepted only in IDLE. In any other state it is ignored.
- Host read is always active: `host_rdata` <= `regs[host_raddr]`. The same bypass rule applies against the host write.
- Control FSM:
  - IDLE: `host_start`=1 → ISSUE.
  - ISSUE: `opflag`=1 for exactly this cycle → WAIT; reset the timeout counter.
  - WAIT: rising edge of `eop` (eop=1 and eop_q=0) → DONE. If the timeout counter reaches `TIMEOUT`-1 → ABORT. Otherwise increment the counter.
  - DONE: `host_done`=1; increment `op_count` (wraps modulo 2^`CNT_W`) → IDLE.
  - ABORT: `host_err`=1 → IDLE. `op_count` is unchanged.
- `host_busy` = 1 in ISSUE, WAIT, DONE and ABORT.
- `host_start` outside IDLE is ignored; it is not queued.
- An `eop` level that is already high on entry to WAIT does not complete the operation; only a fresh 0→1 edge does.
- If an eop edge and the timeout occur in the same cycle, the eop edge wins → DONE.

## Timing
- Reset values: all registers 0, `data_bus`=0, `host_rdata`=0, `opflag`=0, `host_busy`=0, `host_done`=0, `host_err`=0, `op_count`=0, eop_q=0, state IDLE.
- Reset asserted mid-operation returns to IDLE next edge and clears register contents.
- Read latency is one cycle: address sampled at edge N, data valid after edge N.
- Write lands at the sampling edge and is visible to a read addressed in the following cycle, or in the same cycle via bypass.
- `host_start` at edge N: ISSUE after N, so `opflag` is high during cycle N+1.
- Minimum start-to-`host_done` latency: 4 cycles (IDLE→ISSUE→WAIT, eop edge seen, DONE).

## Structure
- Package `kore_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE, ABORT);
  - `KORE_XLEN`=32;
  - `KORE_NREG`=32;
  - `KORE_RSEL_W`=5.
- One sub-module, `kore_rf_mem`: 32x32 array with one write port, two registered read ports and x0 masking.
- The control FSM, write arbitration and counters live in `kore_regbank`.

## Test plan
- Reset, host write x5=0x1234_5678, host_raddr=5 → host_rdata=0x1234_5678 one cycle later; write to x0 then read → 0.
- host_start → opflag high exactly one cycle, host_busy=1; eop 0→1 after 3 cycles → host_done pulse, op_count=1, host_busy=0.
- In WAIT: wt_en=1, reg_sel=7, wr_data=0xDEAD_BEEF with reg_rd=1, reg_sel=7 in the same cycle → data_bus=0xDEAD_BEEF next cycle (bypass).
- host_we=1 during WAIT for x3 → x3 unchanged; FSM write during IDLE → ignored.
- TIMEOUT=8, no eop → host_err pulse 8 cycles after entering WAIT, op_count unchanged; eop held high across the next start → no DONE until eop falls and rises again.
- Assert rst during WAIT → next cycle IDLE, all outputs 0, x5 reads 0.
